pipelined_adder: RTL and testbench

PIPELINED_ADDER -- requirements
Module: pipelined_adder

---
 rtl/pipelined_adder.sv | 95 +++++++++
 tb/tb_pipelined_adder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: add/subtract with the carry chain cut into STAGES registered chunks and a global stall
`ifndef WORD
`define WORD 42
`endif
module pipelined_adder #(
  parameter int WIDTH  = `WORD,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CW = WIDTH / STAGES;
  logic en;
  if (STAGES < 1 || STAGES > WIDTH || WIDTH % STAGES != 0) begin : g_bad
    $error("pipelined_adder: STAGES must be in 1..WIDTH and divide WIDTH");
  end
  assign en = !out_valid || out_ready;
  assign in_ready = en;
  for (genvar k = 0; k < STAGES; k++) begin : st
    localparam int IW = WIDTH - k * CW;
    logic [IW-1:0]    ia, ib;
    logic [WIDTH-1:0] si, s, ns;
    logic             ci, iv, c, v;
    logic [CW:0]      part;
    if (k == 0) begin : g_src
      assign ia = a;
      assign ib = b ^ {WIDTH{sub}};
      assign si = '0;
      assign ci = sub;
      assign iv = in_valid;
    end else begin : g_src
      assign ia = st[k-1].g_up.ua;
      assign ib = st[k-1].g_up.ub;
      assign si = st[k-1].s;
      assign ci = st[k-1].c;
      assign iv = st[k-1].v;
    end
    // add this stage's chunk with the incoming carry and merge it into the partial sum
    always_comb begin
      part = {1'b0, ia[CW-1:0]} + {1'b0, ib[CW-1:0]} + {{CW{1'b0}}, ci};
      ns = si;
      ns[k*CW +: CW] = part[CW-1:0];
    end
    // stage register: valid, chunk carry and completed low sum bits
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        c <= 1'b0;
        s <= '0;
      end else if (en) begin
        v <= iv;
        c <= part[CW];
        s <= ns;
      end
    end
    if (IW > CW) begin : g_up
      logic [IW-CW-1:0] ua, ub;
      // unprocessed upper operand chunks travel with the op
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ua <= '0;
          ub <= '0;
        end else if (en) begin
          ua <= ia[IW-1:CW];
          ub <= ib[IW-1:CW];
        end
      end
    end else begin : g_out
      assign out_valid = v;
      assign sum       = s;
      assign carry_out = c;
      // flags need the operand MSBs, which are only still present in the final stage
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          overflow <= 1'b0;
          zero     <= 1'b0;
        end else if (en) begin
          overflow <= (ia[IW-1] == ib[IW-1]) && (ns[WIDTH-1] != ia[IW-1]);
          zero     <= ns == '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized self-checking bench against a queue-based reference model
module tb_pipelined_adder;
  localparam int W = 42;
  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         v;
    logic         z;
  } res_t;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, sub, out_valid, out_ready, carry_out, overflow, zero;
  logic [W-1:0] a, b, sum;
  int           n_cmp = 0, n_bad = 0;
  res_t         q[$];

  pipelined_adder #(.WIDTH(W), .STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .carry_out(carry_out), .overflow(overflow), .zero(zero)
  );

  always #5 clk = ~clk;

  function automatic res_t model(logic [W-1:0] x, logic [W-1:0] y, logic m);
    res_t   r;
    longint sx, sy, sr;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    sr = m ? sx - sy : sx + sy;
    u = m ? {1'b0, x} - {1'b0, y} : {1'b0, x} + {1'b0, y};
    r.s = u[W-1:0];
    r.c = m ? (x >= y) : u[W];
    r.v = (sr > 64'sd2199023255551) || (sr < -64'sd2199023255552);
    r.z = u[W-1:0] == '0;
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(string tag, res_t e);
    chk({tag, "_valid"}, 64'(out_valid), 64'd1);
    chk({tag, "_sum"}, 64'(sum), 64'(e.s));
    chk({tag, "_carry"}, 64'(carry_out), 64'(e.c));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e.v));
    chk({tag, "_zero"}, 64'(zero), 64'(e.z));
  endtask

  task automatic one(string tag, logic [W-1:0] x, logic [W-1:0] y, logic m, res_t e);
    a = x;
    b = y;
    sub = m;
    in_valid = 1'b1;
    #1 chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    sub = ~m;
    a = W'({$urandom(), $urandom()});
    #1 chk({tag, "_lat"}, 64'(out_valid), 64'd0);
    tick();
    chk_out(tag, e);
  endtask

  initial begin
    res_t e, hv;
    logic held;
    int   issued, cyc;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    a = '0;
    b = '0;
    sub = 1'b0;
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    chk("rst_flags", {61'd0, carry_out, overflow, zero}, 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    one("add11", 42'd1, 42'd1, 1'b0, '{s: 42'd2, c: 1'b0, v: 1'b0, z: 1'b0});
    one("wrap", 42'd4398046511103, 42'd1, 1'b0, '{s: 42'd0, c: 1'b1, v: 1'b0, z: 1'b1});
    one("chunk", 42'd2097151, 42'd1, 1'b0, '{s: 42'd2097152, c: 1'b0, v: 1'b0, z: 1'b0});
    one("sovf", 42'd2199023255551, 42'd1, 1'b0, '{s: 42'd2199023255552, c: 1'b0, v: 1'b1, z: 1'b0});
    one("sub57", 42'd5, 42'd7, 1'b1, '{s: 42'd4398046511102, c: 1'b0, v: 1'b0, z: 1'b0});
    // back-to-back with a 4-cycle consumer stall
    sub = 1'b0;
    in_valid = 1'b1;
    a = 42'd1;
    b = 42'd1;
    tick();
    a = 42'd2;
    b = 42'd2;
    tick();
    a = 42'd3;
    b = 42'd3;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_rdy", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_sum", 64'(sum), 64'd2);
      tick();
    end
    out_ready = 1'b1;
    #1 chk("rel_rdy", 64'(in_ready), 64'd1);
    chk("rel_sum0", 64'(sum), 64'd2);
    tick();
    in_valid = 1'b0;
    #1 chk("rel_sum1", 64'(sum), 64'd4);
    chk("rel_valid1", 64'(out_valid), 64'd1);
    tick();
    chk("rel_sum2", 64'(sum), 64'd6);
    chk("rel_valid2", 64'(out_valid), 64'd1);
    tick();
    // reset in the middle of an operation
    a = 42'd1023;
    b = 42'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("pre_rst_valid", 64'(out_valid), 64'd1);
    chk("pre_rst_sum", 64'(sum), 64'd1024);
    a = 42'd1023;
    b = 42'd1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_out", {21'd0, sum, carry_out, overflow, zero}, 64'd0);
    chk("arst_ready", 64'(in_ready), 64'd1);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_none", 64'(out_valid), 64'd0);
    end
    // randomized traffic against the queue model
    issued = 0;
    cyc = 0;
    held = 1'b0;
    hv = '0;
    while (issued < 10000 && cyc < 60000) begin
      in_valid = $urandom_range(3) != 0;
      a = W'({$urandom(), $urandom()});
      b = W'({$urandom(), $urandom()});
      sub = 1'($urandom_range(1));
      out_ready = $urandom_range(3) != 0;
      #1;
      if (held) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", {21'd0, sum, carry_out, overflow, zero}, 64'(hv));
      end
      held = out_valid && !out_ready;
      hv = '{s: sum, c: carry_out, v: overflow, z: zero};
      if (out_valid && out_ready) begin
        chk("rand_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk_out("rand", e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, sub));
        issued++;
      end
      tick();
      cyc++;
    end
    chk("rand_issued", 64'(issued), 64'd10000);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      #1;
      if (out_valid) begin
        e = q.pop_front();
        chk_out("drain", e);
      end
      tick();
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
    tick();
    chk("drain_idle", 64'(out_valid), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
